// File: rtl/ccsds_pack_pkg.sv
// Shared constants and FSM state type for the codeword packer.
package ccsds_pack_pkg;

   localparam int unsigned OUT_WIDTH_DEF = 32;
   localparam int unsigned ACC_WIDTH_DEF = 128;
   localparam int unsigned LEN_W         = 6;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } pack_state_e;

endpackage

// File: rtl/codeword_align.sv
// Places a right-aligned codeword MSB-first at bit offset fill_i, counted
// down from the accumulator MSB. Bits above len_i in the input are masked off.
module codeword_align
   import ccsds_pack_pkg::*;
#(
   parameter int unsigned DATA_W = 54,
   parameter int unsigned ACC_W  = 128,
   parameter int unsigned FILL_W = 8
) (
   input  logic [DATA_W-1:0] data_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic [FILL_W-1:0] fill_i,
   output logic [ACC_W-1:0]  aligned_o
);

   logic [ACC_W-1:0]  data_ext;
   logic [ACC_W-1:0]  len_mask;
   logic [FILL_W+1:0] shamt;

   always_comb begin
      data_ext = ACC_W'(data_i);
      len_mask = ~({ACC_W{1'b1}} << len_i);
      // Only meaningful when fill+len fits; otherwise the result is discarded.
      shamt = (FILL_W+2)'(ACC_W) - (FILL_W+2)'(fill_i) - (FILL_W+2)'(len_i);
      aligned_o = (data_ext & len_mask) << shamt;
   end

endmodule

// File: rtl/codeword_packer.sv
// Packs variable-length codewords MSB-first into OUT_WIDTH words with flush.
// Optional segment bit counter output enabled by CODEWORD_PACKER_BITCOUNT_EN.
module codeword_packer
   import ccsds_pack_pkg::*;
#(
   parameter int unsigned ENCODE_DATALENGTH = 54,
   parameter int unsigned OUT_WIDTH         = OUT_WIDTH_DEF,
   parameter int unsigned ACC_WIDTH         = ACC_WIDTH_DEF
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         encode_match_i,
   input  logic [LEN_W-1:0]             encode_match_length_i,
   input  logic [ENCODE_DATALENGTH-1:0] encode_match_data_i,
   input  logic                         last_i,
   output logic                         word_valid_o,
   input  logic                         word_ready_i,
   output logic [OUT_WIDTH-1:0]         word_data_o,
   output logic                         word_last_o,
   output logic                         overflow_o,
   output logic                         err_o
`ifdef CODEWORD_PACKER_BITCOUNT_EN
   ,
   output logic [31:0]                  seg_bits_o
`endif
);

   localparam int unsigned FILL_W = $clog2(ACC_WIDTH + 1);
   localparam int unsigned SUM_W  = FILL_W + 1;

   pack_state_e            state_q, state_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [FILL_W-1:0]      fill_q, fill_d;
   logic                   word_valid_q, word_valid_d;
   logic [OUT_WIDTH-1:0]   word_data_q, word_data_d;
   logic                   word_last_q, word_last_d;
   logic                   overflow_q, overflow_d;
   logic                   err_q, err_d;

   logic                   len_err;
   logic [LEN_W-1:0]       len_clamp;
   logic [SUM_W-1:0]       fill_sum;
   logic [SUM_W-1:0]       fill_add;
   logic [ACC_WIDTH-1:0]   aligned;
   logic [ACC_WIDTH-1:0]   acc_nxt;
   logic                   append;
   logic                   extract;
   logic                   extract_last;
   logic                   out_free;
   logic                   accepted;

   codeword_align #(
      .DATA_W (ENCODE_DATALENGTH),
      .ACC_W  (ACC_WIDTH),
      .FILL_W (FILL_W)
   ) u_align (
      .data_i    (encode_match_data_i),
      .len_i     (len_clamp),
      .fill_i    (fill_q),
      .aligned_o (aligned)
   );

   always_comb begin
      len_err   = encode_match_i && (32'(encode_match_length_i) > ENCODE_DATALENGTH);
      len_clamp = len_err ? LEN_W'(ENCODE_DATALENGTH) : encode_match_length_i;
      fill_sum  = SUM_W'(fill_q) + SUM_W'(len_clamp);
   end

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      fill_d       = fill_q;
      word_valid_d = word_valid_q;
      word_data_d  = word_data_q;
      word_last_d  = word_last_q;
      overflow_d   = overflow_q;
      err_d        = err_q;
      append       = 1'b0;
      extract      = 1'b0;
      extract_last = 1'b0;
      out_free     = !word_valid_q || word_ready_i;
      accepted     = word_valid_q && word_ready_i;

      if (accepted) begin
         word_valid_d = 1'b0;
      end

      case (state_q)
         ST_RUN: begin
            if (encode_match_i && (len_clamp != '0)) begin
               if (len_err) begin
                  err_d = 1'b1;
               end
               if (fill_sum <= SUM_W'(ACC_WIDTH)) begin
                  append = 1'b1;
               end else begin
                  overflow_d = 1'b1;
               end
            end
            extract = out_free && (fill_q >= FILL_W'(OUT_WIDTH));
            if (last_i) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (encode_match_i) begin
               err_d = 1'b1;
            end
            // A pending final word blocks further loads until it is taken.
            if (accepted && word_last_q) begin
               state_d = ST_RUN;
            end else if (out_free && !(word_valid_q && word_last_q)) begin
               extract      = 1'b1;
               extract_last = (fill_q <= FILL_W'(OUT_WIDTH));
            end
         end
         default: state_d = ST_RUN;
      endcase

      // Extraction decision uses pre-append fill, so the top word is never
      // touched by a same-cycle append.
      acc_nxt  = append ? (acc_q | aligned) : acc_q;
      fill_add = append ? fill_sum : SUM_W'(fill_q);

      if (extract) begin
         word_valid_d = 1'b1;
         word_data_d  = acc_nxt[ACC_WIDTH-1 -: OUT_WIDTH];
         word_last_d  = extract_last;
         acc_d        = acc_nxt << OUT_WIDTH;
         fill_d       = extract_last ? '0 : FILL_W'(fill_add - SUM_W'(OUT_WIDTH));
      end else begin
         acc_d  = acc_nxt;
         fill_d = FILL_W'(fill_add);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_RUN;
         acc_q        <= '0;
         fill_q       <= '0;
         word_valid_q <= 1'b0;
         word_data_q  <= '0;
         word_last_q  <= 1'b0;
         overflow_q   <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         fill_q       <= fill_d;
         word_valid_q <= word_valid_d;
         word_data_q  <= word_data_d;
         word_last_q  <= word_last_d;
         overflow_q   <= overflow_d;
         err_q        <= err_d;
      end
   end

   assign word_valid_o = word_valid_q;
   assign word_data_o  = word_data_q;
   assign word_last_o  = word_last_q;
   assign overflow_o   = overflow_q;
   assign err_o        = err_q;

`ifdef CODEWORD_PACKER_BITCOUNT_EN
   logic [31:0] seg_cnt_q, seg_cnt_d;
   logic [31:0] seg_bits_q, seg_bits_d;
   logic [31:0] seg_cnt_plus;

   always_comb begin
      seg_cnt_d    = seg_cnt_q;
      seg_bits_d   = seg_bits_q;
      seg_cnt_plus = seg_cnt_q + (append ? 32'(len_clamp) : 32'd0);
      if ((state_q == ST_RUN) && last_i) begin
         seg_bits_d = seg_cnt_plus;
         seg_cnt_d  = '0;
      end else begin
         seg_cnt_d = seg_cnt_plus;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         seg_cnt_q  <= '0;
         seg_bits_q <= '0;
      end else begin
         seg_cnt_q  <= seg_cnt_d;
         seg_bits_q <= seg_bits_d;
      end
   end

   assign seg_bits_o = seg_bits_q;
`endif

endmodule

// File: tb/tb_codeword_packer.sv
// Self-checking bench for codeword_packer: directed table, corner sequences,
// and randomized traffic against a bit-queue reference model.
module tb_codeword_packer;

   localparam int unsigned DL = 54;
   localparam int unsigned OW = 32;
   localparam int unsigned AW = 128;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          em    = 1'b0;
   logic [5:0]    len   = '0;
   logic [DL-1:0] data  = '0;
   logic          last  = 1'b0;
   logic          ready = 1'b0;
   logic          word_valid;
   logic [OW-1:0] word_data;
   logic          word_last;
   logic          overflow;
   logic          err;
`ifdef CODEWORD_PACKER_BITCOUNT_EN
   logic [31:0]   seg_bits;
`endif

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   bit ref_bits[$];
   bit            m_flush, m_full, m_last, m_ovf, m_err;
   logic [OW-1:0] m_data;

   logic [OW-1:0] got_d;
   logic          got_l;
   bit            got_ok;

   typedef struct {
      logic [5:0]    len;
      logic [DL-1:0] data;
      int unsigned   nwords;
      logic [OW-1:0] w0;
      logic [OW-1:0] w1;
      logic          err;
   } vec_t;
   vec_t vecs[9];

   codeword_packer #(
      .ENCODE_DATALENGTH (DL),
      .OUT_WIDTH         (OW),
      .ACC_WIDTH         (AW)
   ) dut (
      .clk_i                 (clk),
      .rst_i                 (rst),
      .encode_match_i        (em),
      .encode_match_length_i (len),
      .encode_match_data_i   (data),
      .last_i                (last),
      .word_valid_o          (word_valid),
      .word_ready_i          (ready),
      .word_data_o           (word_data),
      .word_last_o           (word_last),
      .overflow_o            (overflow),
      .err_o                 (err)
`ifdef CODEWORD_PACKER_BITCOUNT_EN
      ,
      .seg_bits_o            (seg_bits)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      em   = 1'b0;
      len  = '0;
      data = '0;
      last = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      ready = 1'b0;
      rst   = 1'b1;
      #1;
      check("rst_valid", 64'(word_valid), 64'd0);
      check("rst_data", 64'(word_data), 64'd0);
      check("rst_last", 64'(word_last), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      check("rst_err", 64'(err), 64'd0);
`ifdef CODEWORD_PACKER_BITCOUNT_EN
      check("rst_segbits", 64'(seg_bits), 64'd0);
`endif
      step();
      rst = 1'b0;
   endtask

   task automatic get_word(output logic [OW-1:0] d, output logic l, output bit ok);
      ok = 1'b0;
      d  = '0;
      l  = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (word_valid && ready) begin
            d  = word_data;
            l  = word_last;
            ok = 1'b1;
         end
         step();
      end
   endtask

   function automatic void ref_append(input int unsigned n, input logic [DL-1:0] d);
      for (int i = int'(n) - 1; i >= 0; i--) ref_bits.push_back(d[i]);
   endfunction

   function automatic logic [OW-1:0] ref_take();
      logic [OW-1:0] w = '0;
      for (int i = 0; i < int'(OW); i++) begin
         if (ref_bits.size() > 0) w[OW-1-i] = ref_bits.pop_front();
      end
      return w;
   endfunction

   // Reference: bit queue plus output-register occupancy, one call per clock.
   task automatic model_step();
      int unsigned pre_fill = ref_bits.size();
      bit pre_full = m_full;
      bit pre_last = m_last;
      bit free = !pre_full || ready;
      int unsigned l;
      if (pre_full && ready) m_full = 1'b0;
      if (!m_flush) begin
         if (em && len != 0) begin
            l = (int'(len) > int'(DL)) ? DL : int'(len);
            if (int'(len) > int'(DL)) m_err = 1'b1;
            if (pre_fill + l > AW) m_ovf = 1'b1;
            else ref_append(l, data);
         end
         if (free && pre_fill >= OW) begin
            m_data = ref_take();
            m_last = 1'b0;
            m_full = 1'b1;
         end
         if (last) m_flush = 1'b1;
      end else begin
         if (em) m_err = 1'b1;
         if (pre_full && pre_last && ready) begin
            m_flush = 1'b0;
         end else if (free && !(pre_full && pre_last)) begin
            m_last = (pre_fill <= OW);
            m_data = ref_take();
            m_full = 1'b1;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DL-1:0] cw[4];
      logic [OW-1:0] ew[4];
      logic [63:0]   r64;
      bit            saw_valid;

      vecs[0] = '{len: 6'd3,  data: 54'h5,                nwords: 1, w0: 32'hA0000000, w1: 32'h0,        err: 1'b0};
      vecs[1] = '{len: 6'd8,  data: 54'hA5,               nwords: 1, w0: 32'hA5000000, w1: 32'h0,        err: 1'b0};
      vecs[2] = '{len: 6'd0,  data: 54'h3FF,              nwords: 1, w0: 32'h00000000, w1: 32'h0,        err: 1'b0};
      vecs[3] = '{len: 6'd32, data: 54'h3F_0000_DEAD_BEEF, nwords: 1, w0: 32'hDEADBEEF, w1: 32'h0,        err: 1'b0};
      vecs[4] = '{len: 6'd33, data: 54'h1_0000_0001,      nwords: 2, w0: 32'h80000000, w1: 32'h80000000, err: 1'b0};
      vecs[5] = '{len: 6'd60, data: 54'h3F_FFFF_FFFF_FFFF, nwords: 2, w0: 32'hFFFFFFFF, w1: 32'hFFFFFC00, err: 1'b1};
      vecs[6] = '{len: 6'd54, data: 54'h2A_AAAA_AAAA_AAAA, nwords: 2, w0: 32'hAAAAAAAA, w1: 32'hAAAAA800, err: 1'b0};
      vecs[7] = '{len: 6'd5,  data: 54'h3F_FFFF_FFFF_FFF3, nwords: 1, w0: 32'h98000000, w1: 32'h0,        err: 1'b0};
      vecs[8] = '{len: 6'd1,  data: 54'h1,                nwords: 1, w0: 32'h80000000, w1: 32'h0,        err: 1'b0};

      // Single codeword with last_i in the same cycle, then flush.
      for (int v = 0; v < 9; v++) begin
         do_reset();
         ready = 1'b1;
         em    = 1'b1;
         len   = vecs[v].len;
         data  = vecs[v].data;
         last  = 1'b1;
         step();
         idle();
         for (int k = 0; k < int'(vecs[v].nwords); k++) begin
            get_word(got_d, got_l, got_ok);
            check($sformatf("vec%0d_w%0d_seen", v, k), 64'(got_ok), 64'd1);
            check($sformatf("vec%0d_w%0d_data", v, k), 64'(got_d), 64'(k == 0 ? vecs[v].w0 : vecs[v].w1));
            check($sformatf("vec%0d_w%0d_last", v, k), 64'(got_l), 64'(k == int'(vecs[v].nwords) - 1));
         end
         check($sformatf("vec%0d_err", v), 64'(err), 64'(vecs[v].err));
         step();
         step();
         check($sformatf("vec%0d_no_extra", v), 64'(word_valid), 64'd0);
      end

      // Four 8-bit codewords fill one word; valid appears one edge later.
      do_reset();
      ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         em   = 1'b1;
         len  = 6'd8;
         data = 54'hA5;
         step();
      end
      idle();
      check("a5_not_yet", 64'(word_valid), 64'd0);
      step();
      check("a5_valid", 64'(word_valid), 64'd1);
      check("a5_data", 64'(word_data), 64'hA5A5A5A5);
      check("a5_last", 64'(word_last), 64'd0);
      step();
      check("a5_taken", 64'(word_valid), 64'd0);

      // last_i on its own cycle, then the block must accept a new segment.
      do_reset();
      ready = 1'b1;
      em    = 1'b1;
      len   = 6'd3;
      data  = 54'h5;
      step();
      idle();
      last = 1'b1;
      step();
      last = 1'b0;
      get_word(got_d, got_l, got_ok);
      check("sep_last_seen", 64'(got_ok), 64'd1);
      check("sep_last_data", 64'(got_d), 64'hA0000000);
      check("sep_last_flag", 64'(got_l), 64'd1);
      for (int i = 0; i < 4; i++) begin
         em   = 1'b1;
         len  = 6'd8;
         data = 54'hA5;
         step();
      end
      idle();
      get_word(got_d, got_l, got_ok);
      check("rerun_seen", 64'(got_ok), 64'd1);
      check("rerun_data", 64'(got_d), 64'hA5A5A5A5);
      check("rerun_last", 64'(got_l), 64'd0);
      check("rerun_err", 64'(err), 64'd0);

      // Back-pressure overflow: third and fourth 54-bit codewords dropped.
      do_reset();
      ref_bits.delete();
      for (int i = 0; i < 4; i++) begin
         r64   = {$urandom, $urandom};
         cw[i] = r64[DL-1:0];
      end
      ref_append(DL, cw[0]);
      ref_append(DL, cw[1]);
      for (int i = 0; i < 4; i++) ew[i] = ref_take();
      for (int i = 0; i < 4; i++) begin
         em   = 1'b1;
         len  = 6'd54;
         data = cw[i];
         step();
         check($sformatf("ovf_after_cw%0d", i), 64'(overflow), 64'(i >= 2));
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("hold_valid%0d", i), 64'(word_valid), 64'd1);
         check($sformatf("hold_data%0d", i), 64'(word_data), 64'(ew[0]));
         step();
      end
      last = 1'b1;
      step();
      last  = 1'b0;
      ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         get_word(got_d, got_l, got_ok);
         check($sformatf("drain%0d_seen", k), 64'(got_ok), 64'd1);
         check($sformatf("drain%0d_data", k), 64'(got_d), 64'(ew[k]));
         check($sformatf("drain%0d_last", k), 64'(got_l), 64'(k == 3));
      end
      check("drain_err", 64'(err), 64'd0);
      check("drain_ovf", 64'(overflow), 64'd1);

      // Reset mid-segment discards pending bits and the held word at once.
      do_reset();
      for (int i = 0; i < 2; i++) begin
         em   = 1'b1;
         len  = 6'd20;
         data = 54'hFFFFF;
         step();
      end
      idle();
      step();
      check("pre_rst_valid", 64'(word_valid), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", 64'(word_valid), 64'd0);
      check("async_rst_data", 64'(word_data), 64'd0);
      check("async_rst_last", 64'(word_last), 64'd0);
      step();
      rst   = 1'b0;
      ready = 1'b1;
      saw_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (word_valid) saw_valid = 1'b1;
      end
      check("post_rst_no_words", 64'(saw_valid), 64'd0);

`ifdef CODEWORD_PACKER_BITCOUNT_EN
      do_reset();
      ready = 1'b1;
      em = 1'b1; len = 6'd3;  data = 54'h5;     step();
      em = 1'b1; len = 6'd8;  data = 54'hA5;    step();
      em = 1'b1; len = 6'd20; data = 54'hABCDE; step();
      idle();
      last = 1'b1;
      step();
      last = 1'b0;
      check("seg_bits", 64'(seg_bits), 64'd31);
      for (int i = 0; i < 6; i++) step();
      check("seg_bits_hold", 64'(seg_bits), 64'd31);
`endif

      // Randomized traffic against the reference model.
      do_reset();
      ref_bits.delete();
      m_flush = 1'b0; m_full = 1'b0; m_last = 1'b0;
      m_ovf   = 1'b0; m_err  = 1'b0; m_data = '0;
      for (int c = 0; c < 700; c++) begin
         if (c < 640) begin
            r64   = {$urandom, $urandom};
            em    = ($urandom % 10) < 7;
            len   = (($urandom % 10) == 0) ? 6'($urandom_range(55, 63)) : 6'($urandom_range(0, 54));
            data  = r64[DL-1:0];
            last  = ($urandom % 25) == 0;
            ready = ($urandom % 10) < 7;
         end else begin
            idle();
            ready = 1'b1;
         end
         model_step();
         step();
         check("rnd_valid", 64'(word_valid), 64'(m_full));
         if (m_full) begin
            check("rnd_data", 64'(word_data), 64'(m_data));
            check("rnd_last", 64'(word_last), 64'(m_last));
         end
      end
      check("rnd_ovf", 64'(overflow), 64'(m_ovf));
      check("rnd_err", 64'(err), 64'(m_err));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
